color_frame_classifier: RTL

- Downstream consumer of the TCS3200 colour-detection stage.
- Periodically snapshots the four 21-bit period counts (red, green, blue, clear) and classifies each snapshot against per-colour reference windows.
- Debounces the result over consecutive snapshots and reports each colour change to the bot controller through a valid/ready handshake.
- Drives one-hot indicator LEDs for the last acknowledged colour.

---
 rtl/color_frame_classifier.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/color_frame_classifier.sv
// Snapshots TCS3200 period counts, classifies them against reference windows,
// debounces and reports colour changes via valid/ready. Option: COLOR_NONE_REPORT_EN.
module color_frame_classifier #(
   parameter int unsigned SAMPLE_DIV   = 50000,
   parameter int unsigned STABLE_COUNT = 4,
   parameter int unsigned TOL          = 200,
   parameter int unsigned RED_REF_R    = 1010,
   parameter int unsigned RED_REF_G    = 1543,
   parameter int unsigned RED_REF_B    = 1370,
   parameter int unsigned RED_REF_C    = 480,
   parameter int unsigned GREEN_REF_R  = 800,
   parameter int unsigned GREEN_REF_G  = 775,
   parameter int unsigned GREEN_REF_B  = 800,
   parameter int unsigned GREEN_REF_C  = 275,
   parameter int unsigned BLUE_REF_R   = 1800,
   parameter int unsigned BLUE_REF_G   = 1630,
   parameter int unsigned BLUE_REF_B   = 970,
   parameter int unsigned BLUE_REF_C   = 485
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic [20:0] red_cnt,
   input  logic [20:0] green_cnt,
   input  logic [20:0] blue_cnt,
   input  logic [20:0] clear_cnt,
   output logic [1:0]  color_code,
   output logic        color_valid,
   input  logic        color_ready,
   output logic        red_led,
   output logic        green_led,
   output logic        blue_led
);
   localparam int unsigned CNT_W = 21;
   localparam int unsigned CMP_W = CNT_W + 1;
   localparam int unsigned DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned STB_W = 4;

   typedef enum logic [1:0] {IDLE, CLASSIFY, FILTER, REPORT} state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   snap_r_q, snap_r_d, snap_g_q, snap_g_d;
   logic [CNT_W-1:0]   snap_b_q, snap_b_d, snap_c_q, snap_c_d;
   logic [1:0]         cand_q, cand_d;
   logic [1:0]         last_cand_q, last_cand_d;
   logic [STB_W-1:0]   stable_q, stable_d;
   logic [1:0]         reported_q, reported_d;
   logic [1:0]         code_q, code_d;
   logic               valid_q, valid_d;
   logic [2:0]         led_q, led_d;

   logic               tick_c;
   logic               red_hit_c, green_hit_c, blue_hit_c;
   logic [1:0]         cand_c;
   logic [STB_W-1:0]   stable_nxt_c;
   logic               report_hit_c;

   // Strict window test; lower edge clamps to zero when TOL reaches the centre.
   function automatic logic in_win(input logic [CNT_W-1:0] v, input int unsigned ref_v);
      logic [CMP_W-1:0] lo;
      logic [CMP_W-1:0] hi;
      logic [CMP_W-1:0] x;
      lo = (TOL >= ref_v) ? '0 : CMP_W'(ref_v - TOL);
      hi = CMP_W'(ref_v + TOL);
      x  = {1'b0, v};
      return (x > lo) && (x < hi);
   endfunction

   assign tick_c = (div_q == DIV_W'(SAMPLE_DIV - 1));

   assign red_hit_c   = in_win(snap_r_q, RED_REF_R)   && in_win(snap_g_q, RED_REF_G) &&
                        in_win(snap_b_q, RED_REF_B)   && in_win(snap_c_q, RED_REF_C);
   assign green_hit_c = in_win(snap_r_q, GREEN_REF_R) && in_win(snap_g_q, GREEN_REF_G) &&
                        in_win(snap_b_q, GREEN_REF_B) && in_win(snap_c_q, GREEN_REF_C);
   assign blue_hit_c  = in_win(snap_r_q, BLUE_REF_R)  && in_win(snap_g_q, BLUE_REF_G) &&
                        in_win(snap_b_q, BLUE_REF_B)  && in_win(snap_c_q, BLUE_REF_C);
   assign cand_c = red_hit_c ? 2'd1 : (green_hit_c ? 2'd2 : (blue_hit_c ? 2'd3 : 2'd0));

   // Debounce: run length of identical candidates and the report decision.
   always_comb begin
      stable_nxt_c = stable_q;
      report_hit_c = 1'b0;
      if (cand_q == last_cand_q) begin
         if (stable_q >= STB_W'(STABLE_COUNT)) stable_nxt_c = STB_W'(STABLE_COUNT);
         else                                  stable_nxt_c = stable_q + STB_W'(1);
      end else begin
         stable_nxt_c = STB_W'(1);
      end
`ifdef COLOR_NONE_REPORT_EN
      report_hit_c = (stable_nxt_c == STB_W'(STABLE_COUNT)) && (cand_q != reported_q);
`else
      report_hit_c = (stable_nxt_c == STB_W'(STABLE_COUNT)) && (cand_q != reported_q) &&
                     (cand_q != 2'd0);
`endif
   end

   always_ff @(posedge clk_50M) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (tick_c) state_d = CLASSIFY;
         CLASSIFY: state_d = FILTER;
         FILTER:   state_d = report_hit_c ? REPORT : IDLE;
         REPORT:   if (color_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      div_d       = tick_c ? '0 : div_q + DIV_W'(1);
      snap_r_d    = snap_r_q;
      snap_g_d    = snap_g_q;
      snap_b_d    = snap_b_q;
      snap_c_d    = snap_c_q;
      cand_d      = cand_q;
      last_cand_d = last_cand_q;
      stable_d    = stable_q;
      reported_d  = reported_q;
      code_d      = code_q;
      valid_d     = valid_q;
      case (state_q)
         IDLE: begin
            if (tick_c) begin
               snap_r_d = red_cnt;
               snap_g_d = green_cnt;
               snap_b_d = blue_cnt;
               snap_c_d = clear_cnt;
            end
         end
         CLASSIFY: cand_d = cand_c;
         FILTER: begin
            last_cand_d = cand_q;
            stable_d    = stable_nxt_c;
            if (report_hit_c) begin
               code_d  = cand_q;
               valid_d = 1'b1;
            end
         end
         REPORT: begin
            if (color_ready) begin
               valid_d    = 1'b0;
               reported_d = code_q;
            end
         end
         default: ;
      endcase
      // LEDs follow the acknowledged colour on the acknowledge edge.
      case (reported_d)
         2'd1:    led_d = 3'b100;
         2'd2:    led_d = 3'b010;
         2'd3:    led_d = 3'b001;
         default: led_d = 3'b000;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         div_q       <= '0;
         snap_r_q    <= '0;
         snap_g_q    <= '0;
         snap_b_q    <= '0;
         snap_c_q    <= '0;
         cand_q      <= '0;
         last_cand_q <= '0;
         stable_q    <= '0;
         reported_q  <= '0;
         code_q      <= '0;
         valid_q     <= 1'b0;
         led_q       <= '0;
      end else begin
         div_q       <= div_d;
         snap_r_q    <= snap_r_d;
         snap_g_q    <= snap_g_d;
         snap_b_q    <= snap_b_d;
         snap_c_q    <= snap_c_d;
         cand_q      <= cand_d;
         last_cand_q <= last_cand_d;
         stable_q    <= stable_d;
         reported_q  <= reported_d;
         code_q      <= code_d;
         valid_q     <= valid_d;
         led_q       <= led_d;
      end
   end

   assign color_code  = code_q;
   assign color_valid = valid_q;
   assign red_led     = led_q[2];
   assign green_led   = led_q[1];
   assign blue_led    = led_q[0];

endmodule
